// File: rtl/relay_pkg.sv
// Shared types and timing defaults for the channel relayer: flight modes,
// mode-controller states and the mapping between modes and select/request bits.
package relay_pkg;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    CRUISE = 2'd1,
    AUTO   = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_GAP = 2'd2,
    ST_FAULT    = 2'd3
  } state_t;

  localparam int unsigned CLK_HZ                  = 50_000_000;
  localparam int unsigned ACK_TIMEOUT_CYC_DEFAULT = 5_000_000;
  localparam int unsigned GAP_CYC_DEFAULT         = 50_000;

  // Pilot switches to target mode; autonomous wins over cruise.
  function automatic mode_t target_mode(input logic auto_sw, input logic cruise_sw);
    if (auto_sw)        return AUTO;
    else if (cruise_sw) return CRUISE;
    else                return MANUAL;
  endfunction

  // One-hot select/request pair {autonomous, cruise}; MANUAL is both low.
  function automatic logic [1:0] mode_bits(input mode_t m);
    case (m)
      AUTO:    return 2'b10;
      CRUISE:  return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic mode_t bits_mode(input logic [1:0] b);
    if (b[1])      return AUTO;
    else if (b[0]) return CRUISE;
    else           return MANUAL;
  endfunction

endpackage

// File: rtl/pwm_gap_detector.sv
// Synchronizes the OR of all relayed PWM lines and reports when they have been
// quiet for GAP_CYC consecutive cycles, i.e. a safe moment to switch the mux.
module pwm_gap_detector
  import relay_pkg::*;
#(
  parameter int unsigned GAP_CYC = GAP_CYC_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pwm_active_i,
  output logic window_open_o
);

  localparam int unsigned CW = $clog2(GAP_CYC + 1);
  localparam logic [CW-1:0] GAP_MAX = CW'(GAP_CYC);

  logic          pwm_meta_q;
  logic          pwm_sync_q;
  logic [CW-1:0] gap_cnt_q;
  logic [CW-1:0] gap_cnt_d;

  // Any pulse activity restarts the quiet interval; the count saturates.
  always_comb begin
    gap_cnt_d = gap_cnt_q;
    if (pwm_sync_q) begin
      gap_cnt_d = '0;
    end else if (gap_cnt_q != GAP_MAX) begin
      gap_cnt_d = gap_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pwm_meta_q <= 1'b0;
      pwm_sync_q <= 1'b0;
      gap_cnt_q  <= '0;
    end else begin
      pwm_meta_q <= pwm_active_i;
      pwm_sync_q <= pwm_meta_q;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign window_open_o = (gap_cnt_q == GAP_MAX);

endmodule

// File: rtl/relay_mode_controller.sv
// Flight-mode sequencer: arbitrates pilot requests, runs the level req/ack
// handshake with the RPi and commits mux selects only inside a PWM quiet gap.
module relay_mode_controller
  import relay_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT_CYC = ACK_TIMEOUT_CYC_DEFAULT,
  parameter int unsigned GAP_CYC         = GAP_CYC_DEFAULT
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       AUTO_SW,
  input  logic       CRUISE_SW,
  input  logic       RPI_Ack_AUTONOMOUS,
  input  logic       RPI_Ack_CRUISE,
  input  logic       PWM_ACTIVE,
  output logic       RPI_Req_AUTONOMOUS,
  output logic       RPI_Req_CRUISE,
  output logic       AUTONOMOUS_MODE,
  output logic       CRUISE_CONTROL_MODE,
  output logic       MODE_FAULT,
  output logic [1:0] STATE
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMEOUT = TW'(ACK_TIMEOUT_CYC);

  state_t        state_q;
  logic [1:0]    req_q;
  logic [1:0]    commit_q;
  logic [TW-1:0] timer_q;
  logic          fault_q;
  logic [1:0]    ack_meta_q;
  logic [1:0]    ack_sync_q;

  mode_t target;
  mode_t req_mode;
  mode_t committed;
  logic  hs_met;
  logic  window_open;

  pwm_gap_detector #(
    .GAP_CYC(GAP_CYC)
  ) u_gap (
    .clk_i        (CLOCK_50),
    .rst_ni       (RESET_N),
    .pwm_active_i (PWM_ACTIVE),
    .window_open_o(window_open)
  );

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      ack_meta_q <= 2'b00;
      ack_sync_q <= 2'b00;
    end else begin
      ack_meta_q <= {RPI_Ack_AUTONOMOUS, RPI_Ack_CRUISE};
      ack_sync_q <= ack_meta_q;
    end
  end

  // Level handshake: the RPi acknowledges by mirroring both request lines;
  // the handshake holds for as long as the synced acks equal the requests.
  assign target    = target_mode(AUTO_SW, CRUISE_SW);
  assign req_mode  = bits_mode(req_q);
  assign committed = bits_mode(commit_q);
  assign hs_met    = (ack_sync_q == req_q);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      req_q    <= 2'b00;
      commit_q <= 2'b00;
      timer_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (target != committed) begin
            req_q   <= mode_bits(target);
            timer_q <= '0;
            state_q <= ST_REQ;
          end else if (hs_met) begin
            timer_q <= '0;
          end else if (timer_q == TIMEOUT) begin
            // RPi dropped its ack on a settled mode.
            state_q <= ST_FAULT;
            fault_q <= 1'b1;
            req_q   <= mode_bits(MANUAL);
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_REQ: begin
          if (target != req_mode) begin
            req_q   <= mode_bits(target);
            timer_q <= '0;
          end else if (hs_met) begin
            state_q <= ST_WAIT_GAP;
          end else if (timer_q == TIMEOUT) begin
            state_q <= ST_FAULT;
            fault_q <= 1'b1;
            req_q   <= mode_bits(MANUAL);
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_WAIT_GAP: begin
          if (target != req_mode) begin
            req_q   <= mode_bits(target);
            timer_q <= '0;
            state_q <= ST_REQ;
          end else if (!hs_met) begin
            timer_q <= '0;
            state_q <= ST_REQ;
          end else if (window_open) begin
            commit_q <= req_q;
            timer_q  <= '0;
            state_q  <= ST_IDLE;
          end
        end
        ST_FAULT: begin
          // MANUAL is forced without an ack; leaving needs the pilot and RPi to agree.
          if (target == MANUAL && committed == MANUAL && hs_met) begin
            fault_q <= 1'b0;
            timer_q <= '0;
            state_q <= ST_IDLE;
          end else if (window_open && committed != MANUAL) begin
            commit_q <= mode_bits(MANUAL);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign RPI_Req_AUTONOMOUS  = req_q[1];
  assign RPI_Req_CRUISE      = req_q[0];
  assign AUTONOMOUS_MODE     = commit_q[1];
  assign CRUISE_CONTROL_MODE = commit_q[0];
  assign MODE_FAULT          = fault_q;
  assign STATE               = state_q;

endmodule

// File: tb/tb_relay_mode_controller.sv
// Bench for relay_mode_controller with short timing constants: directed
// scenarios push expected output changes, a negedge monitor pops and compares.
module tb_relay_mode_controller;

  localparam int unsigned ACK_TO = 100;
  localparam int unsigned GAP    = 10;
  localparam int W = 39;

  logic       clk;
  logic       rst_n;
  logic       auto_sw;
  logic       cruise_sw;
  logic       ack_a;
  logic       ack_c;
  logic       pwm;
  logic       req_a;
  logic       req_c;
  logic       auto_m;
  logic       cruise_m;
  logic       fault;
  logic [1:0] state;
  logic [6:0] vec;
  logic [6:0] prev_vec;
  logic [W-1:0] e;
  logic [W-1:0] exp_q[$];

  int checks;
  int errors;
  int unsigned cyc;

  relay_mode_controller #(
    .ACK_TIMEOUT_CYC(ACK_TO),
    .GAP_CYC        (GAP)
  ) dut (
    .CLOCK_50           (clk),
    .RESET_N            (rst_n),
    .AUTO_SW            (auto_sw),
    .CRUISE_SW          (cruise_sw),
    .RPI_Ack_AUTONOMOUS (ack_a),
    .RPI_Ack_CRUISE     (ack_c),
    .PWM_ACTIVE         (pwm),
    .RPI_Req_AUTONOMOUS (req_a),
    .RPI_Req_CRUISE     (req_c),
    .AUTONOMOUS_MODE    (auto_m),
    .CRUISE_CONTROL_MODE(cruise_m),
    .MODE_FAULT         (fault),
    .STATE              (state)
  );

  // Output vector: {req_a, req_c, auto_mode, cruise_mode, fault, state[1:0]}
  assign vec = {req_a, req_c, auto_m, cruise_m, fault, state};

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic pwm_lvl);
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    auto_sw   = 1'b0;
    cruise_sw = 1'b0;
    ack_a     = 1'b0;
    ack_c     = 1'b0;
    pwm       = pwm_lvl;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  function automatic logic [W-1:0] mk(input logic [6:0] v, input int unsigned c);
    return {c, v};
  endfunction

  task automatic expect_at(input logic [6:0] v, input int unsigned c);
    exp_q.push_back(mk(v, c));
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vec = vec;
    end else if (vec !== prev_vec) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cycle=%0d got=%b", cyc, vec);
      end else begin
        e = exp_q.pop_front();
        if (e[6:0] !== vec || e[38:7] != cyc) begin
          errors++;
          $display("FAIL event got=%b@%0d expected=%b@%0d", vec, cyc, e[6:0], e[38:7]);
        end
      end
      prev_vec = vec;
    end
  end

  // ---------------- stimulus ----------------
  int unsigned n, m, p, q, r;

  initial begin
    checks    = 0;
    errors    = 0;
    auto_sw   = 1'b0;
    cruise_sw = 1'b0;
    ack_a     = 1'b0;
    ack_c     = 1'b0;
    pwm       = 1'b0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (vec !== 7'b0000000) begin
      errors++;
      $display("FAIL reset_state got=%b expected=%b", vec, 7'b0000000);
    end

    // 1: AUTO request, ack after 5 cycles, commit one cycle after gap count hits 10
    do_reset(1'b1);
    wait_cyc(3);
    n = cyc;
    auto_sw = 1'b1;
    expect_at(7'b1000001, n + 1);
    wait_cyc(6);
    ack_a = 1'b1;
    expect_at(7'b1000010, n + 9);
    wait_cyc(5);
    m = cyc;
    pwm = 1'b0;
    expect_at(7'b1010000, m + 13);
    wait_cyc(20);

    // 2: both switches set, AUTO wins; minimum latency with open window
    do_reset(1'b0);
    wait_cyc(15);
    n = cyc;
    auto_sw   = 1'b1;
    cruise_sw = 1'b1;
    expect_at(7'b1000001, n + 1);
    wait_cyc(1);
    ack_a = 1'b1;
    expect_at(7'b1000010, n + 4);
    expect_at(7'b1010000, n + 5);
    wait_cyc(10);
    cruise_sw = 1'b0;
    wait_cyc(10);

    // 3: CRUISE request never acked -> fault at timeout, exit when pilot returns to MANUAL
    do_reset(1'b0);
    wait_cyc(15);
    n = cyc;
    cruise_sw = 1'b1;
    expect_at(7'b0100001, n + 1);
    expect_at(7'b0000111, n + 102);
    wait_cyc(110);
    p = cyc;
    cruise_sw = 1'b0;
    expect_at(7'b0000000, p + 1);
    wait_cyc(10);

    // 4: handshake met but PWM pulses every 8 cycles -> no commit until a real gap
    do_reset(1'b1);
    wait_cyc(2);
    n = cyc;
    cruise_sw = 1'b1;
    ack_c     = 1'b1;
    expect_at(7'b0100001, n + 1);
    expect_at(7'b0100010, n + 3);
    for (int i = 0; i < 6; i++) begin
      pwm = 1'b1;
      wait_cyc(1);
      pwm = 1'b0;
      m = cyc;
      wait_cyc(7);
    end
    expect_at(7'b0101000, m + 13);
    wait_cyc(15);

    // 5: switch from AUTO to CRUISE mid-request restarts the timeout
    do_reset(1'b0);
    wait_cyc(15);
    n = cyc;
    auto_sw = 1'b1;
    expect_at(7'b1000001, n + 1);
    expect_at(7'b0100001, n + 51);
    wait_cyc(50);
    auto_sw   = 1'b0;
    cruise_sw = 1'b1;
    wait_cyc(70);
    ack_c = 1'b1;
    expect_at(7'b0100010, n + 123);
    expect_at(7'b0101000, n + 124);
    wait_cyc(20);

    // 6: committed AUTO, ack dropped -> fault, MANUAL forced at next window
    do_reset(1'b0);
    wait_cyc(15);
    n = cyc;
    auto_sw = 1'b1;
    ack_a   = 1'b1;
    expect_at(7'b1000001, n + 1);
    expect_at(7'b1000010, n + 3);
    expect_at(7'b1010000, n + 4);
    wait_cyc(10);
    pwm = 1'b1;
    wait_cyc(2);
    p = cyc;
    ack_a = 1'b0;
    expect_at(7'b0010111, p + 103);
    wait_cyc(110);
    m = cyc;
    pwm = 1'b0;
    expect_at(7'b0000111, m + 13);
    wait_cyc(20);
    r = cyc;
    auto_sw = 1'b0;
    expect_at(7'b0000000, r + 1);
    wait_cyc(5);

    // 7: reset during a new handshake drops the committed mode immediately
    n = cyc;
    auto_sw = 1'b1;
    ack_a   = 1'b1;
    expect_at(7'b1000001, n + 1);
    expect_at(7'b1000010, n + 3);
    expect_at(7'b1010000, n + 4);
    wait_cyc(6);
    pwm = 1'b1;
    wait_cyc(3);
    q = cyc;
    auto_sw   = 1'b0;
    cruise_sw = 1'b1;
    expect_at(7'b0110001, q + 1);
    wait_cyc(3);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (vec !== 7'b0000000) begin
      errors++;
      $display("FAIL async_reset got=%b expected=%b", vec, 7'b0000000);
    end
    repeat (3) @(posedge clk);

    // ---------------- report ----------------
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event got=none expected=%b@%0d", e[6:0], e[38:7]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
